// File: rtl/csr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_arb_pkg
// Description : Shared types for the CSR arbiter (state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package csr_arb_pkg;

   // IDLE grants new requests; WAIT_RSP holds the slave for one pending read.
   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/csr_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : csr_rr_pick
// Description : Combinational circular priority picker. Returns the first
//               set bit of 'valid' searching upward from 'start' with
//               wrap-around, and whether any bit was set at all.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_rr_pick #(
   parameter int NumReq  = 2,
   parameter int IdWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]  valid,
   input  logic [IdWidth-1:0] start,
   output logic [IdWidth-1:0] win,
   output logic               found
);

   // Walk the requesters in circular order from 'start'; the first valid wins.
   always_comb begin
      int idx;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NumReq; i++) begin
         idx = int'(start) + i;
         if (idx >= NumReq) begin
            idx = idx - NumReq;
         end
         for (int k = 0; k < NumReq; k++) begin
            if (!found && (k == idx) && valid[k]) begin
               found = 1'b1;
               win   = IdWidth'(k);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : csr_arbiter
// Description : Shares one CSR slave port between NumReq requesters. Grants
//               are round-robin and forwarded combinationally; a read whose
//               response is not taken in the grant cycle parks the arbiter
//               in WAIT_RSP until the response completes, with the response
//               routed back to the issuing requester.
// Config      : CSR_ARB_FIXED_PRIO_EN - when defined, lowest index always
//               wins and no round-robin pointer exists.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_arbiter
   import csr_arb_pkg::*;
#(
   parameter int NumReq       = 2,
   parameter int CsrDataWidth = 32,
   parameter int CsrAddrWidth = 32,
   parameter int IdWidth      = $clog2(NumReq)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   // requester side
   input  logic [NumReq-1:0][CsrDataWidth-1:0]  s_req_data_i,
   input  logic [NumReq-1:0][CsrAddrWidth-1:0]  s_req_addr_i,
   input  logic [NumReq-1:0]                    s_req_write_i,
   input  logic [NumReq-1:0]                    s_req_valid_i,
   output logic [NumReq-1:0]                    s_req_ready_o,
   output logic [NumReq-1:0][CsrDataWidth-1:0] s_rsp_data_o,
   output logic [NumReq-1:0]                    s_rsp_valid_o,
   input  logic [NumReq-1:0]                    s_rsp_ready_i,
   // CSR slave side
   output logic [CsrDataWidth-1:0]              m_req_data_o,
   output logic [CsrAddrWidth-1:0]              m_req_addr_o,
   output logic                                 m_req_write_o,
   output logic                                 m_req_valid_o,
   input  logic                                 m_req_ready_i,
   input  logic [CsrDataWidth-1:0]              m_rsp_data_i,
   input  logic                                 m_rsp_valid_i,
   output logic                                 m_rsp_ready_o,
   // status
   output logic                                 arb_busy_o,
   output logic [IdWidth-1:0]                   arb_owner_o
);

   arb_state_e         state_q, state_d;
   logic [IdWidth-1:0] owner_q, owner_d;
   logic               hold_valid_q, hold_valid_d;
   logic [IdWidth-1:0] hold_id_q, hold_id_d;

   logic [IdWidth-1:0] pick_start;
   logic [IdWidth-1:0] pick_win;
   logic               pick_found;
   logic [IdWidth-1:0] win;
   logic               win_valid;
   logic [IdWidth-1:0] next_ptr;

`ifdef CSR_ARB_FIXED_PRIO_EN
   // Fixed priority: the search always starts at requester 0.
   assign pick_start = '0;
`else
   logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;

   // Round-robin pointer: the requester after the last accepted one goes first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign pick_start = rr_ptr_q;
`endif

   csr_rr_pick #(
      .NumReq  (NumReq),
      .IdWidth (IdWidth)
   ) u_pick (
      .valid (s_req_valid_i),
      .start (pick_start),
      .win   (pick_win),
      .found (pick_found)
   );

   // A stalled grant is pinned to its requester so fields stay stable.
   assign win       = hold_valid_q ? hold_id_q : pick_win;
   assign win_valid = hold_valid_q | pick_found;

   // Pointer successor of the current winner, wrapping at NumReq.
   always_comb begin
      int nxt;
      nxt = int'(win) + 1;
      if (nxt >= NumReq) begin
         nxt = 0;
      end
      next_ptr = IdWidth'(nxt);
   end

   // State, read owner and grant-hold registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         hold_valid_q <= 1'b0;
         hold_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         hold_valid_q <= hold_valid_d;
         hold_id_q    <= hold_id_d;
      end
   end

   // Next-state and all port outputs; everything reads 0 while in reset.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      hold_valid_d  = 1'b0;
      hold_id_d     = '0;
`ifndef CSR_ARB_FIXED_PRIO_EN
      rr_ptr_d      = rr_ptr_q;
`endif
      s_req_ready_o = '0;
      s_rsp_data_o  = '0;
      s_rsp_valid_o = '0;
      m_req_data_o  = '0;
      m_req_addr_o  = '0;
      m_req_write_o = 1'b0;
      m_req_valid_o = 1'b0;
      m_rsp_ready_o = 1'b0;
      arb_busy_o    = 1'b0;
      arb_owner_o   = '0;

      if (rst_ni) begin
         s_rsp_data_o = {NumReq{m_rsp_data_i}};
         case (state_q)
            IDLE: begin
               arb_owner_o   = win;
               // Without a read handshake this cycle, stray responses drop.
               m_rsp_ready_o = 1'b1;
               if (win_valid) begin
                  m_req_valid_o      = 1'b1;
                  m_req_data_o       = s_req_data_i[win];
                  m_req_addr_o       = s_req_addr_i[win];
                  m_req_write_o      = s_req_write_i[win];
                  s_req_ready_o[win] = m_req_ready_i;
                  if (m_req_ready_i) begin
`ifndef CSR_ARB_FIXED_PRIO_EN
                     rr_ptr_d = next_ptr;
`endif
                     if (!s_req_write_i[win]) begin
                        s_rsp_valid_o[win] = m_rsp_valid_i;
                        m_rsp_ready_o      = s_rsp_ready_i[win];
                        if (!(m_rsp_valid_i && s_rsp_ready_i[win])) begin
                           owner_d = win;
                           state_d = WAIT_RSP;
                        end
                     end
                  end else begin
                     hold_valid_d = 1'b1;
                     hold_id_d    = win;
                  end
               end
            end
            WAIT_RSP: begin
               arb_busy_o             = 1'b1;
               arb_owner_o            = owner_q;
               s_rsp_valid_o[owner_q] = m_rsp_valid_i;
               m_rsp_ready_o          = s_rsp_ready_i[owner_q];
               if (m_rsp_valid_i && s_rsp_ready_i[owner_q]) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // next_ptr is only consumed by the round-robin pointer.
`ifdef CSR_ARB_FIXED_PRIO_EN
   logic unused_next_ptr;
   assign unused_next_ptr = ^next_ptr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_arbiter
// Description : Directed self-checking bench for csr_arbiter (NumReq = 2).
//               Honours CSR_ARB_FIXED_PRIO_EN to select the expected policy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int IW = 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [N-1:0][DW-1:0]  s_req_data = '0;
   logic [N-1:0][AW-1:0]  s_req_addr = '0;
   logic [N-1:0]          s_req_write = '0;
   logic [N-1:0]          s_req_valid = '0;
   logic [N-1:0]          s_req_ready;
   logic [N-1:0][DW-1:0]  s_rsp_data;
   logic [N-1:0]          s_rsp_valid;
   logic [N-1:0]          s_rsp_ready = '0;
   logic [DW-1:0]         m_req_data;
   logic [AW-1:0]         m_req_addr;
   logic                  m_req_write;
   logic                  m_req_valid;
   logic                  m_req_ready = 1'b0;
   logic [DW-1:0]         m_rsp_data = '0;
   logic                  m_rsp_valid = 1'b0;
   logic                  m_rsp_ready;
   logic                  arb_busy;
   logic [IW-1:0]         arb_owner;

   int total = 0;
   int bad   = 0;

   csr_arbiter #(
      .NumReq       (N),
      .CsrDataWidth (DW),
      .CsrAddrWidth (AW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .s_req_data_i  (s_req_data),
      .s_req_addr_i  (s_req_addr),
      .s_req_write_i (s_req_write),
      .s_req_valid_i (s_req_valid),
      .s_req_ready_o (s_req_ready),
      .s_rsp_data_o  (s_rsp_data),
      .s_rsp_valid_o (s_rsp_valid),
      .s_rsp_ready_i (s_rsp_ready),
      .m_req_data_o  (m_req_data),
      .m_req_addr_o  (m_req_addr),
      .m_req_write_o (m_req_write),
      .m_req_valid_o (m_req_valid),
      .m_req_ready_i (m_req_ready),
      .m_rsp_data_i  (m_rsp_data),
      .m_rsp_valid_i (m_rsp_valid),
      .m_rsp_ready_o (m_rsp_ready),
      .arb_busy_o    (arb_busy),
      .arb_owner_o   (arb_owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset: outputs must be 0 even with live inputs ----
      #1;
      s_req_valid = 2'b11;
      s_req_write = 2'b11;
      s_req_addr[0] = 32'h10;
      m_req_ready = 1'b1;
      m_rsp_valid = 1'b1;
      m_rsp_data  = 32'hDEAD;
      s_rsp_ready = 2'b11;
      #1;
      check("rst_m_valid", 32'(m_req_valid), 32'h0);
      check("rst_s_ready", 32'(s_req_ready), 32'h0);
      check("rst_m_addr",  m_req_addr, 32'h0);
      check("rst_rsp_val", 32'(s_rsp_valid), 32'h0);
      check("rst_rsp_dat", s_rsp_data[0], 32'h0);
      check("rst_m_rrdy",  32'(m_rsp_ready), 32'h0);
      check("rst_busy",    32'(arb_busy), 32'h0);
      step();
      rst_n = 1'b1;
      m_rsp_valid = 1'b0;

`ifdef CSR_ARB_FIXED_PRIO_EN
      // ---- fixed priority: req0 always wins, req1 starves ----
      s_req_addr[0] = 32'h10;
      s_req_addr[1] = 32'h20;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("fp_ready", 32'(s_req_ready), 32'h1);
         check("fp_addr",  m_req_addr, 32'h10);
         step();
      end
`else
      // ---- back-to-back writes alternate 0,1,0,1 ----
      s_req_addr[0] = 32'h10;
      s_req_addr[1] = 32'h20;
      s_req_data[0] = 32'h1111;
      s_req_data[1] = 32'h2222;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("wr_addr",  m_req_addr, (i % 2 == 1) ? 32'h20 : 32'h10);
         check("wr_data",  m_req_data, (i % 2 == 1) ? 32'h2222 : 32'h1111);
         check("wr_ready", 32'(s_req_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
         check("wr_busy",  32'(arb_busy), 32'h0);
         step();
      end

      // ---- req0 read with same-cycle response ----
      s_req_valid = 2'b01;
      s_req_write = 2'b00;
      s_req_addr[0] = 32'h1;
      m_rsp_valid = 1'b1;
      m_rsp_data  = 32'hA5;
      #1;
      check("rd0_addr",    m_req_addr, 32'h1);
      check("rd0_write",   32'(m_req_write), 32'h0);
      check("rd0_rsp_val", 32'(s_rsp_valid), 32'h1);
      check("rd0_rsp_dat", s_rsp_data[0], 32'hA5);
      check("rd0_m_rrdy",  32'(m_rsp_ready), 32'h1);
      check("rd0_busy",    32'(arb_busy), 32'h0);
      step();
      // stray response with no request pending: dropped
      s_req_valid = 2'b00;
      #1;
      check("stray_busy",  32'(arb_busy), 32'h0);
      check("stray_val",   32'(s_rsp_valid), 32'h0);
      check("stray_rrdy",  32'(m_rsp_ready), 32'h1);
      m_rsp_valid = 1'b0;

      // ---- req1 read with response held off for 3 cycles ----
      s_req_valid = 2'b10;
      s_req_addr[1] = 32'h200;
      s_rsp_ready = 2'b00;
      #1;
      check("rd1_ready", 32'(s_req_ready), 32'h2);
      check("rd1_owner", 32'(arb_owner), 32'h1);
      step();
      s_req_valid = 2'b01;
      s_req_write = 2'b01;
      s_req_addr[0] = 32'h30;
      m_rsp_valid = 1'b1;
      m_rsp_data  = 32'h5A;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("wt_busy",    32'(arb_busy), 32'h1);
         check("wt_s_ready", 32'(s_req_ready), 32'h0);
         check("wt_m_valid", 32'(m_req_valid), 32'h0);
         check("wt_rsp_val", 32'(s_rsp_valid), 32'h2);
         check("wt_m_rrdy",  32'(m_rsp_ready), 32'h0);
         check("wt_owner",   32'(arb_owner), 32'h1);
         step();
      end
      s_rsp_ready = 2'b10;
      #1;
      check("done_rsp_val", 32'(s_rsp_valid), 32'h2);
      check("done_rsp_dat", s_rsp_data[1], 32'h5A);
      check("done_m_rrdy",  32'(m_rsp_ready), 32'h1);
      check("done_m_valid", 32'(m_req_valid), 32'h0);
      step();
      m_rsp_valid = 1'b0;
      s_rsp_ready = 2'b11;
      #1;
      check("after_busy",  32'(arb_busy), 32'h0);
      check("after_addr",  m_req_addr, 32'h30);
      check("after_ready", 32'(s_req_ready), 32'h1);
      step();

      // ---- grant hold while slave stalls (pointer favours req1) ----
      s_req_valid = 2'b01;
      s_req_write = 2'b11;
      s_req_addr[0] = 32'h40;
      s_req_addr[1] = 32'h50;
      m_req_ready = 1'b0;
      #1;
      check("hold_addr0",  m_req_addr, 32'h40);
      check("hold_ready0", 32'(s_req_ready), 32'h0);
      step();
      s_req_valid = 2'b11;
      #1;
      check("hold_addr1",  m_req_addr, 32'h40);
      check("hold_owner1", 32'(arb_owner), 32'h0);
      step();
      m_req_ready = 1'b1;
      #1;
      check("hold_addr2",  m_req_addr, 32'h40);
      check("hold_ready2", 32'(s_req_ready), 32'h1);
      step();
      s_req_valid = 2'b10;
      #1;
      check("hold_next",   m_req_addr, 32'h50);
      check("hold_nready", 32'(s_req_ready), 32'h2);
      step();
`endif

      // ---- reset asserted during WAIT_RSP ----
      s_req_valid = 2'b01;
      s_req_write = 2'b00;
      s_req_addr[0] = 32'h60;
      s_req_addr[1] = 32'h50;
      m_req_ready = 1'b1;
      m_rsp_valid = 1'b0;
      s_rsp_ready = 2'b00;
      #1;
      check("mr_ready", 32'(s_req_ready), 32'h1);
      step();
      s_req_valid = 2'b00;
      m_rsp_valid = 1'b1;
      m_rsp_data  = 32'h77;
      #1;
      check("mr_busy", 32'(arb_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mr_rst_busy",  32'(arb_busy), 32'h0);
      check("mr_rst_val",   32'(s_rsp_valid), 32'h0);
      check("mr_rst_dat",   s_rsp_data[0], 32'h0);
      check("mr_rst_rrdy",  32'(m_rsp_ready), 32'h0);
      check("mr_rst_owner", 32'(arb_owner), 32'h0);
      step();
      rst_n = 1'b1;
      m_rsp_valid = 1'b0;
      s_rsp_ready = 2'b11;
      s_req_valid = 2'b11;
      s_req_write = 2'b11;
      #1;
      check("mr_post_busy",  32'(arb_busy), 32'h0);
      check("mr_post_ready", 32'(s_req_ready), 32'h1);
      check("mr_post_addr",  m_req_addr, 32'h60);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
